instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the instruction ROM: owns the program counter, drives the ROM word address, and captures the combinational ROM data each cycle. Fetched instructions are buffered in a small FIFO and handed to decode over a valid/ready handshake. Supports a one-cycle redirect from branch/jump resolution that flushes the buffer and reloads the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
imem_addr  output  32  byte address to ROM; equals fetch_pc.
imem_data  input  32  instruction word from ROM, combinational from imem_addr, same cycle.
redirect_valid  input  1  one-cycle pulse: flush and jump to redirect_pc.
redirect_pc  input  32  redirect target byte address.
out_valid  output  1  buffer head holds a valid instruction.
out_ready  input  1  decode accepts head this cycle.
out_instr  output  32  instruction at buffer head.
out_pc  output  32  PC of out_instr.
out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
misalign_err  output  1  registered one-cycle pulse: last redirect target had [1:0] != 0.
fetch_cnt  output  32  count of completed handshakes (out_valid && out_ready), wraps at 2^32.

Behaviour:
- Reset (async, immediate): fetch_pc = RESET_PC; FIFO empty (count=0, rd/wr pointers 0); out_valid=0; misalign_err=0; fetch_cnt=0. out_instr/out_pc read 0 while empty.
- imem_addr = fetch_pc combinationally; no internal ROM latency assumed.
- push = !redirect_valid && (count < FIFO_DEPTH || pop). On push: write {fetch_pc, imem_data} at wr pointer; fetch_pc <= fetch_pc + 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000).
- If no push and no redirect, fetch_pc holds.
- pop = out_valid && out_ready; advances rd pointer; fetch_cnt increments.
- Push and pop in one cycle when full: both occur; count unchanged.
- out_valid = (count != 0). Head outputs come from FIFO storage (registered), so first out_valid rises on the first rising edge after reset release, carrying RESET_PC.
- While out_valid && !out_ready, out_instr/out_pc/out_pc_plus4 hold stable.
- Redirect (redirect_valid=1 at edge): pop in same cycle still counts (fetch_cnt increments); then FIFO flushed (count=0, pointers 0); no push; fetch_pc <= {redirect_pc[31:2], 2'b00}. out_valid=0 the following cycle; target instruction appears one cycle after that.
- misalign_err <= redirect_valid && (redirect_pc[1:0] != 0); otherwise 0 next cycle.
- Back-to-back redirects: each reloads fetch_pc; only the last target is fetched.
- Pointer wrap: rd/wr pointers modulo FIFO_DEPTH; count in range 0..FIFO_DEPTH.
- Reset asserted mid-operation overrides redirect and handshake; buffered entries discarded.

Test Plan:
- Reset release, ROM[0]=0x0020_81B3, ROM[1]=0x4020_8233, out_ready=1 -> cycle 1 out_pc=0x0, out_instr=0x0020_81B3; cycle 2 out_pc=0x4, out_instr=0x4020_8233; fetch_cnt=2 after two handshakes.
- out_ready=0 for 5 cycles -> count saturates at 2, imem_addr holds 0x8, out_pc stays 0x0; out_ready=1 -> pcs 0x0,0x4,0x8 in order with no gap or duplicate.
- Full FIFO with out_ready=1 each cycle -> push and pop every cycle, count stays 2, one instruction per cycle.
- redirect_valid pulse, redirect_pc=0x18, while head out_pc=0x4 accepted -> fetch_cnt counts 0x4; next cycle out_valid=0; then out_pc=0x18, out_instr=ROM[6].
- redirect_pc=0x0000_0026 -> fetch resumes at 0x24; misalign_err high exactly one cycle.
- RESET_PC=0xFFFF_FFF8, out_ready=1 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; out_pc_plus4 at 0xFFFF_FFFC equals 0x0; reset asserted mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage that sits directly in front of a combinational instruction ROM.
// It owns the program counter, presents it to the ROM as a byte address, and
// captures the returned word into a small instruction buffer. Decode drains the
// buffer over a valid/ready handshake. A one-cycle redirect from branch/jump
// resolution flushes the buffer and reloads the program counter.
//
// Parameters:
//   RESET_PC    - PC loaded on reset (4-byte aligned)
//   FIFO_DEPTH  - instruction buffer entries (power of two, >= 2)
//
// Ports:
//   clk            - rising-edge system clock
//   reset          - asynchronous, active-high reset
//   imem_addr      - byte address driven to the ROM (current fetch PC)
//   imem_data      - ROM word for imem_addr, valid in the same cycle
//   redirect_valid - one-cycle pulse: flush buffer and jump to redirect_pc
//   redirect_pc    - redirect target byte address
//   out_valid      - buffer head holds a valid instruction
//   out_ready      - decode accepts the head this cycle
//   out_instr      - instruction at the buffer head (0 while empty)
//   out_pc         - PC of out_instr (0 while empty)
//   out_pc_plus4   - out_pc + 4, wrapping at 2^32
//   misalign_err   - registered pulse: previous redirect target was unaligned
//   fetch_cnt      - number of completed handshakes, wrapping at 2^32
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4,
   output logic        misalign_err,
   output logic [31:0] fetch_cnt
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic [31:0]      fetchPc_q, fetchPc_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      fetchCnt_q, fetchCnt_d;
   logic             misalign_q, misalign_d;

   logic [31:0]      instrMem_q [FIFO_DEPTH];
   logic [31:0]      pcMem_q    [FIFO_DEPTH];

   logic             push;
   logic             pop;

   // The ROM is combinational, so the current PC is the ROM address directly.
   assign imem_addr = fetchPc_q;

   // Head outputs come straight from buffer storage and are forced to zero
   // while the buffer is empty so decode never sees stale entries.
   assign out_valid    = (count_q != '0);
   assign out_instr    = out_valid ? instrMem_q[rdPtr_q] : 32'h0;
   assign out_pc       = out_valid ? pcMem_q[rdPtr_q]    : 32'h0;
   assign out_pc_plus4 = out_pc + 32'd4;
   assign misalign_err = misalign_q;
   assign fetch_cnt    = fetchCnt_q;

   // Next-state logic. A pop in a redirect cycle still counts as a completed
   // handshake; the flush then discards everything else. Pushing is allowed
   // into a full buffer when the head leaves in the same cycle.
   always_comb begin
      pop        = out_valid && out_ready;
      push       = !redirect_valid && ((count_q < DEPTH_C) || pop);
      fetchPc_d  = fetchPc_q;
      rdPtr_d    = rdPtr_q;
      wrPtr_d    = wrPtr_q;
      count_d    = count_q;
      fetchCnt_d = fetchCnt_q + (pop ? 32'd1 : 32'd0);
      misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);

      if (redirect_valid) begin
         rdPtr_d   = '0;
         wrPtr_d   = '0;
         count_d   = '0;
         fetchPc_d = {redirect_pc[31:2], 2'b00};
      end else begin
         if (push) begin
            wrPtr_d   = wrPtr_q + PTR_W'(1);
            fetchPc_d = fetchPc_q + 32'd4;
         end
         if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // Control state: PC, buffer pointers/occupancy, handshake counter and the
   // misalignment pulse, all cleared immediately by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetchPc_q  <= RESET_PC;
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
         count_q    <= '0;
         fetchCnt_q <= 32'h0;
         misalign_q <= 1'b0;
      end else begin
         fetchPc_q  <= fetchPc_d;
         rdPtr_q    <= rdPtr_d;
         wrPtr_q    <= wrPtr_d;
         count_q    <= count_d;
         fetchCnt_q <= fetchCnt_d;
         misalign_q <= misalign_d;
      end
   end

   // Buffer storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         instrMem_q[wrPtr_q] <= imem_data;
         pcMem_q[wrPtr_q]    <= fetchPc_q;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Scoreboard bench for instr_fetch_unit. Two instances are used: one with the
// default reset PC for stall/redirect behaviour, and one reset near the top of
// the address space to exercise PC wrap-around and mid-stream reset.
// Stimulus pushes expected PCs into a queue; monitors pop and compare on every
// completed handshake.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   logic        clk;
   logic        reset;
   logic [31:0] imemAddr;
   logic [31:0] imemData;
   logic        redirectValid;
   logic [31:0] redirectPc;
   logic        outValid;
   logic        outReady;
   logic [31:0] outInstr;
   logic [31:0] outPc;
   logic [31:0] outPcPlus4;
   logic        misalignErr;
   logic [31:0] fetchCnt;

   logic        wReset;
   logic [31:0] wImemAddr;
   logic [31:0] wImemData;
   logic        wOutValid;
   logic        wOutReady;
   logic [31:0] wOutInstr;
   logic [31:0] wOutPc;
   logic [31:0] wOutPcPlus4;
   logic        wMisalignErr;
   logic [31:0] wFetchCnt;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] expQ[$];
   logic [31:0] wrapQ[$];
   logic [31:0] mainExp;
   logic [31:0] wrapExp;

   // ROM model: two fixed words at the bottom, a recognisable pattern elsewhere.
   function automatic logic [31:0] romWord(input logic [31:0] addr);
      case (addr)
         32'h0000_0000: romWord = 32'h0020_81B3;
         32'h0000_0004: romWord = 32'h4020_8233;
         default:       romWord = {addr[31:2], 2'b11} ^ 32'h5A5A_0000;
      endcase
   endfunction

   assign imemData  = romWord(imemAddr);
   assign wImemData = romWord(wImemAddr);

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .imem_addr(imemAddr), .imem_data(imemData),
      .redirect_valid(redirectValid), .redirect_pc(redirectPc),
      .out_valid(outValid), .out_ready(outReady), .out_instr(outInstr),
      .out_pc(outPc), .out_pc_plus4(outPcPlus4),
      .misalign_err(misalignErr), .fetch_cnt(fetchCnt)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dutWrap (
      .clk(clk), .reset(wReset), .imem_addr(wImemAddr), .imem_data(wImemData),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .out_valid(wOutValid), .out_ready(wOutReady), .out_instr(wOutInstr),
      .out_pc(wOutPc), .out_pc_plus4(wOutPcPlus4),
      .misalign_err(wMisalignErr), .fetch_cnt(wFetchCnt)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Main-instance monitor: compare every handshake against the scoreboard.
   always @(negedge clk) begin
      if (!reset && outValid && outReady) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL main_unexpected actual=%h required=none", outPc);
         end else begin
            mainExp = expQ.pop_front();
            checkOutput("main_pc", outPc, mainExp);
            checkOutput("main_instr", outInstr, romWord(mainExp));
            checkOutput("main_pc4", outPcPlus4, mainExp + 32'd4);
         end
      end
   end

   // Wrap-instance monitor.
   always @(negedge clk) begin
      if (!wReset && wOutValid && wOutReady) begin
         if (wrapQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL wrap_unexpected actual=%h required=none", wOutPc);
         end else begin
            wrapExp = wrapQ.pop_front();
            checkOutput("wrap_pc", wOutPc, wrapExp);
            checkOutput("wrap_instr", wOutInstr, romWord(wrapExp));
            checkOutput("wrap_pc4", wOutPcPlus4, wrapExp + 32'd4);
         end
      end
   end

   initial begin
      reset         = 1'b1;
      wReset        = 1'b1;
      outReady      = 1'b0;
      wOutReady     = 1'b0;
      redirectValid = 1'b0;
      redirectPc    = 32'h0;
      applyStimulus();
      applyStimulus();

      // Reset state
      checkOutput("rst_valid", {31'h0, outValid}, 32'h0);
      checkOutput("rst_addr", imemAddr, 32'h0);
      checkOutput("rst_cnt", fetchCnt, 32'h0);
      checkOutput("rst_misalign", {31'h0, misalignErr}, 32'h0);
      checkOutput("rst_pc", outPc, 32'h0);
      checkOutput("rst_instr", outInstr, 32'h0);
      checkOutput("rst_wrap_addr", wImemAddr, 32'hFFFF_FFF8);

      // Streaming from reset: pcs 0 and 4 in consecutive cycles
      expQ.push_back(32'h0);
      expQ.push_back(32'h4);
      reset    = 1'b0;
      outReady = 1'b1;
      applyStimulus();
      applyStimulus();
      applyStimulus();
      outReady = 1'b0;
      checkOutput("cnt_after_two", fetchCnt, 32'd2);

      // Stall: buffer fills, head and fetch PC hold
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall_valid", {31'h0, outValid}, 32'h1);
         checkOutput("stall_pc", outPc, 32'h8);
         if (i == 4) checkOutput("stall_addr", imemAddr, 32'h10);
         applyStimulus();
      end

      // Drain a full buffer with push and pop every cycle
      expQ.push_back(32'h8);
      expQ.push_back(32'hC);
      expQ.push_back(32'h10);
      expQ.push_back(32'h14);
      expQ.push_back(32'h18);
      outReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkOutput("full_valid", {31'h0, outValid}, 32'h1);
      end

      // Redirect while head 0x18 is accepted
      redirectValid = 1'b1;
      redirectPc    = 32'h8;
      applyStimulus();
      redirectValid = 1'b0;
      checkOutput("redir_valid_low", {31'h0, outValid}, 32'h0);
      checkOutput("redir_cnt", fetchCnt, 32'd7);
      expQ.push_back(32'h8);
      expQ.push_back(32'hC);
      applyStimulus();
      applyStimulus();

      // Misaligned redirect while head 0xC is accepted
      redirectValid = 1'b1;
      redirectPc    = 32'h26;
      applyStimulus();
      redirectValid = 1'b0;
      checkOutput("misalign_high", {31'h0, misalignErr}, 32'h1);
      checkOutput("misalign_valid", {31'h0, outValid}, 32'h0);
      checkOutput("misalign_addr", imemAddr, 32'h24);
      expQ.push_back(32'h24);
      applyStimulus();
      checkOutput("misalign_low", {31'h0, misalignErr}, 32'h0);

      // Back-to-back redirects: only 0x10 is fetched
      redirectValid = 1'b1;
      redirectPc    = 32'h30;
      applyStimulus();
      redirectPc    = 32'h10;
      checkOutput("b2b_valid", {31'h0, outValid}, 32'h0);
      checkOutput("b2b_misalign", {31'h0, misalignErr}, 32'h0);
      applyStimulus();
      redirectValid = 1'b0;
      checkOutput("b2b_valid2", {31'h0, outValid}, 32'h0);
      checkOutput("b2b_addr", imemAddr, 32'h10);
      expQ.push_back(32'h10);
      expQ.push_back(32'h14);
      applyStimulus();
      applyStimulus();
      applyStimulus();
      outReady = 1'b0;
      checkOutput("final_cnt", fetchCnt, 32'd12);
      checkOutput("main_queue_left", expQ.size(), 32'd0);

      // Wrap instance: PC crosses 0xFFFF_FFFC -> 0
      wrapQ.push_back(32'hFFFF_FFF8);
      wrapQ.push_back(32'hFFFF_FFFC);
      wrapQ.push_back(32'h0000_0000);
      wrapQ.push_back(32'h0000_0004);
      wReset    = 1'b0;
      wOutReady = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulus();
      checkOutput("wrap_cnt", wFetchCnt, 32'd4);
      checkOutput("wrap_valid_pre", {31'h0, wOutValid}, 32'h1);

      // Mid-stream reset takes effect immediately
      wReset = 1'b1;
      #1;
      checkOutput("wrap_rst_valid", {31'h0, wOutValid}, 32'h0);
      checkOutput("wrap_rst_cnt", wFetchCnt, 32'h0);
      checkOutput("wrap_rst_addr", wImemAddr, 32'hFFFF_FFF8);
      checkOutput("wrap_queue_left", wrapQ.size(), 32'd0);
      applyStimulus();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
